frame_rx: RTL and testbench
===========================

FRAME_RX -- requirements
Module: frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame.
REQ-002 Parameter IDLE_LVL, default 1'b1, line level between frames; start bit is ~IDLE_LVL, stop bit is IDLE_LVL.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ser_in  input  1  serial bit from the upstream shift stage, LSB first.
REQ-006 ser_en  input  1  bit strobe; ser_in is sampled only in cycles where ser_en=1.
REQ-007 data_o  output  DATA_W  received payload.
REQ-008 valid_o  output  1  data_o holds a complete, correctly framed word.
REQ-009 ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
REQ-010 frame_err_o  output  1  one-cycle pulse, stop bit sampled at the wrong level.
REQ-011 overrun_o  output  1  one-cycle pulse, start bit sampled while a word is still held.
REQ-012 busy_o  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, DATA, STOP and HOLD, plus PAR when FRAME_RX_PARITY_EN is defined.
REQ-014 IDLE: ser_en && ser_in==~IDLE_LVL SHALL go to DATA and clear the bit counter; other samples are ignored.
REQ-015 DATA: each ser_en SHALL shift ser_in into the shift register at the MSB and shift right, so the first bit lands in data_o[0].
REQ-016 Bit counter SHALL be $clog2(DATA_W+1) bits wide; the DATA_W-th sample in DATA moves to STOP (or PAR).
REQ-017 STOP: ser_en && ser_in==IDLE_LVL SHALL load data_o and go to HOLD; valid_o rises the next cycle.
REQ-018 STOP: ser_en && ser_in!=IDLE_LVL SHALL pulse frame_err_o, discard the word, go to IDLE, and leave data_o unchanged.
REQ-019 HOLD: valid_o=1 and data_o stable until handshake; on valid_o && ready_i the FSM SHALL go to IDLE.
REQ-020 HOLD with ser_en && start level and no handshake SHALL pulse overrun_o and remain in HOLD; that frame is dropped.
REQ-021 HOLD with handshake and ser_en && start level in the same cycle SHALL complete the handshake, go directly to DATA and raise no overrun.
REQ-022 Cycles with ser_en=0 SHALL leave the FSM, counter and shift register unchanged.
REQ-023 Latency from the stop-bit sample cycle to valid_o=1 SHALL be exactly 1 clock.
REQ-024 ready_i SHALL have no effect outside HOLD.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, counter=0, shift register=0, data_o=0, and valid_o, frame_err_o, overrun_o, busy_o=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; the first start bit sampled after release begins a new frame.

Configuration
REQ-027 Macro FRAME_RX_PARITY_EN SHALL control the parity feature.
REQ-028 With the macro defined: state PAR follows DATA; even parity over payload plus parity bit; a mismatch pulses output port parity_err_o and the word is discarded in STOP.
REQ-029 Without the macro: no PAR state and no parity_err_o port; frame length is DATA_W+2.

Structure
REQ-030 Package frame_pkg SHALL hold the state enum typedef, the DATA_W default and the FRAME_LEN constant.
REQ-031 Bit counter SHALL be the sub-module frame_bit_cnt, with inputs clr and inc and output done.

Verification
REQ-032 Send 0xA5 as 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), with ready_i=1 -> data_o=0xA5 and valid_o high for exactly 1 cycle.
REQ-033 Send 0x3C with stop bit 0 -> frame_err_o pulses once, valid_o stays 0, FSM returns to IDLE.
REQ-034 Send 0x11 with ready_i=0, then start a second frame -> overrun_o pulses at the second start bit; data_o stays 0x11 until ready_i=1.
REQ-035 Assert rst=0 after 4 data bits, release, then send 0x7E -> data_o=0x7E with no errors.
REQ-036 Define FRAME_RX_PARITY_EN; send 0x03 with parity bit 1 -> parity_err_o pulses and valid_o stays 0.
REQ-037 Set ser_en high only every 3rd clock while sending 0xFF -> data_o=0xFF; no state change on idle cycles.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// FRAME_RX_PARITY_EN adds the PAR state and one parity bit to the frame.
package frame_pkg;

   localparam int DATA_W_DEF = 8;

`ifdef FRAME_RX_PARITY_EN
   localparam int FRAME_LEN = DATA_W_DEF + 3;
   typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, HOLD} state_t;
`else
   localparam int FRAME_LEN = DATA_W_DEF + 2;
   typedef enum logic [1:0] {IDLE, DATA, STOP, HOLD} state_t;
`endif

endpackage

// File: rtl/frame_bit_cnt.sv
// Payload bit counter for frame_rx.
// The done output flags that the current sample is the last payload bit.
module frame_bit_cnt
   import frame_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic done
);

   localparam int CW = $clog2(DATA_W + 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign done = (r_count == CW'(DATA_W - 1));

endmodule

// File: rtl/frame_rx.sv
// Serial frame receiver: start bit, LSB-first payload, stop bit, one-word hold buffer.
// Define FRAME_RX_PARITY_EN to add an even-parity bit and the parity_err_o port.
module frame_rx
   import frame_pkg::*;
#(
   parameter int   DATA_W   = DATA_W_DEF,
   parameter logic IDLE_LVL = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ser_in,
   input  logic              ser_en,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              frame_err_o,
   output logic              overrun_o,
`ifdef FRAME_RX_PARITY_EN
   output logic              parity_err_o,
`endif
   output logic              busy_o
);

   state_t            r_state;
   logic [DATA_W-1:0] r_shift;
`ifdef FRAME_RX_PARITY_EN
   logic              r_parBad;
`endif

   logic w_start;
   logic w_stopOk;
   logic w_handshake;
   logic w_clr;
   logic w_inc;
   logic w_done;

   assign w_start     = ser_en && (ser_in == ~IDLE_LVL);
   assign w_stopOk    = (ser_in == IDLE_LVL);
   assign w_handshake = valid_o && ready_i;
   assign w_clr       = w_start && ((r_state == IDLE) || ((r_state == HOLD) && w_handshake));
   assign w_inc       = ser_en && (r_state == DATA);

   frame_bit_cnt #(
      .DATA_W (DATA_W)
   ) u_bitCnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_clr),
      .inc  (w_inc),
      .done (w_done)
   );

   // HOLD keeps the last good word; a start seen there without a same-cycle handshake is lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_shift      <= '0;
         data_o       <= '0;
         valid_o      <= 1'b0;
         frame_err_o  <= 1'b0;
         overrun_o    <= 1'b0;
         busy_o       <= 1'b0;
`ifdef FRAME_RX_PARITY_EN
         parity_err_o <= 1'b0;
         r_parBad     <= 1'b0;
`endif
      end else begin
         frame_err_o  <= 1'b0;
         overrun_o    <= 1'b0;
`ifdef FRAME_RX_PARITY_EN
         parity_err_o <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state <= DATA;
                  busy_o  <= 1'b1;
               end
            end
            DATA: begin
               if (ser_en) begin
                  r_shift <= {ser_in, r_shift[DATA_W-1:1]};
                  if (w_done) begin
`ifdef FRAME_RX_PARITY_EN
                     r_state <= PAR;
`else
                     r_state <= STOP;
`endif
                  end
               end
            end
`ifdef FRAME_RX_PARITY_EN
            PAR: begin
               if (ser_en) begin
                  r_parBad     <= ^{r_shift, ser_in};
                  parity_err_o <= ^{r_shift, ser_in};
                  r_state      <= STOP;
               end
            end
`endif
            STOP: begin
               if (ser_en) begin
                  if (!w_stopOk) begin
                     frame_err_o <= 1'b1;
                     r_state     <= IDLE;
                     busy_o      <= 1'b0;
`ifdef FRAME_RX_PARITY_EN
                  end else if (r_parBad) begin
                     r_state <= IDLE;
                     busy_o  <= 1'b0;
`endif
                  end else begin
                     data_o  <= r_shift;
                     valid_o <= 1'b1;
                     r_state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (w_handshake) begin
                  valid_o <= 1'b0;
                  if (w_start) begin
                     r_state <= DATA;
                  end else begin
                     r_state <= IDLE;
                     busy_o  <= 1'b0;
                  end
               end else if (w_start) begin
                  overrun_o <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               valid_o <= 1'b0;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_rx.sv
// Scoreboard bench for frame_rx: directed frames push expected words, a negedge monitor checks handshakes.
// Define FRAME_RX_PARITY_EN to also exercise the parity error path.
`timescale 1ns/1ps
module tb_frame_rx;
   import frame_pkg::*;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       ser_in  = 1'b1;
   logic       ser_en  = 1'b0;
   logic       ready_i = 1'b0;
   logic [7:0] data_o;
   logic       valid_o;
   logic       frame_err_o;
   logic       overrun_o;
   logic       busy_o;
`ifdef FRAME_RX_PARITY_EN
   logic       parity_err_o;
`endif

   int         checks        = 0;
   int         errors        = 0;
   logic [7:0] expQ[$];
   int         frameErrSeen  = 0;
   int         overrunSeen   = 0;
   int         parityErrSeen = 0;
   int         validSeen     = 0;
   int         validRun      = 0;
   int         lastValidRun  = 0;

   always #5 clk = ~clk;

   frame_rx #(
      .DATA_W   (8),
      .IDLE_LVL (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ser_in       (ser_in),
      .ser_en       (ser_en),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .frame_err_o  (frame_err_o),
      .overrun_o    (overrun_o),
`ifdef FRAME_RX_PARITY_EN
      .parity_err_o (parity_err_o),
`endif
      .busy_o       (busy_o)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: counts error pulses and checks each accepted word against the queue.
   always @(negedge clk) begin
      if (frame_err_o) frameErrSeen++;
      if (overrun_o) overrunSeen++;
`ifdef FRAME_RX_PARITY_EN
      if (parity_err_o) parityErrSeen++;
`endif
      if (valid_o) begin
         validSeen++;
         validRun++;
      end else begin
         validRun = 0;
      end
      if (valid_o && ready_i) begin
         lastValidRun = validRun;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedWord: got 0x%0h, want none", data_o);
         end else begin
            checkOutput("word", {24'h0, data_o}, {24'h0, expQ.pop_front()});
         end
      end
   end

   task automatic sendBit(input logic b, input int spacing);
      ser_en = 1'b1;
      ser_in = b;
      @(posedge clk); #1;
      ser_en = 1'b0;
      ser_in = ~b;
      for (int i = 1; i < spacing; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parityFlip, input int spacing);
      sendBit(1'b0, spacing);
      for (int i = 0; i < 8; i++) sendBit(data[i], spacing);
`ifdef FRAME_RX_PARITY_EN
      sendBit((^data) ^ parityFlip, spacing);
`else
      if (parityFlip) $display("[TB] note: parity flip ignored without parity build");
`endif
      sendBit(stopBit, spacing);
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while (expQ.size() != 0 && n < 12 * FRAME_LEN) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput(name, expQ.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int f0, o0, v0, p0;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstData", {24'h0, data_o}, 32'h0);
      checkOutput("rstValid", valid_o, 0);
      checkOutput("rstBusy", busy_o, 0);
      checkOutput("rstFrameErr", frame_err_o, 0);
      checkOutput("rstOverrun", overrun_o, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Basic word with consumer always ready
      ready_i = 1'b1;
      v0 = validSeen;
      f0 = frameErrSeen;
      expQ.push_back(8'hA5);
      applyStimulus(8'hA5, 1'b1, 1'b0, 1);
      waitDrain("drainA5");
      repeat (2) @(posedge clk);
      #1;
      checkOutput("a5ValidCycles", validSeen - v0, 1);
      checkOutput("a5ValidRun", lastValidRun, 1);
      checkOutput("a5Busy", busy_o, 0);
      checkOutput("a5FrameErr", frameErrSeen - f0, 0);

      // Bad stop bit
      v0 = validSeen;
      f0 = frameErrSeen;
      applyStimulus(8'h3C, 1'b0, 1'b0, 1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ferrPulses", frameErrSeen - f0, 1);
      checkOutput("ferrValid", validSeen - v0, 0);
      checkOutput("ferrBusy", busy_o, 0);
      checkOutput("ferrDataKept", {24'h0, data_o}, 32'hA5);

      // Overrun while holding an unaccepted word
      ready_i = 1'b0;
      o0 = overrunSeen;
      expQ.push_back(8'h11);
      applyStimulus(8'h11, 1'b1, 1'b0, 1);
      applyStimulus(8'hFF, 1'b1, 1'b0, 1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ovrPulses", overrunSeen - o0, 1);
      checkOutput("ovrDataHeld", {24'h0, data_o}, 32'h11);
      checkOutput("ovrValidHeld", valid_o, 1);
      ready_i = 1'b1;
      waitDrain("drainOvr");
      @(posedge clk); #1;
      checkOutput("ovrBusy", busy_o, 0);

      // Handshake and next start bit in the same cycle
      ready_i = 1'b0;
      o0 = overrunSeen;
      expQ.push_back(8'h33);
      expQ.push_back(8'hC3);
      applyStimulus(8'h33, 1'b1, 1'b0, 1);
      @(posedge clk); #1;
      ready_i = 1'b1;
      applyStimulus(8'hC3, 1'b1, 1'b0, 1);
      waitDrain("drainB2B");
      checkOutput("b2bOverrun", overrunSeen - o0, 0);

      // Reset in the middle of a frame
      f0 = frameErrSeen;
      o0 = overrunSeen;
      sendBit(1'b0, 1);
      for (int i = 0; i < 4; i++) sendBit(i[0], 1);
      rst = 1'b0;
      #2;
      checkOutput("midRstBusy", busy_o, 0);
      checkOutput("midRstData", {24'h0, data_o}, 32'h0);
      checkOutput("midRstValid", valid_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      expQ.push_back(8'h7E);
      applyStimulus(8'h7E, 1'b1, 1'b0, 1);
      waitDrain("drain7E");
      checkOutput("midRstFrameErr", frameErrSeen - f0, 0);
      checkOutput("midRstOverrun", overrunSeen - o0, 0);

      // Sparse bit strobe with noise on ser_in between strobes
      expQ.push_back(8'hFF);
      applyStimulus(8'hFF, 1'b1, 1'b0, 3);
      expQ.push_back(8'h5A);
      applyStimulus(8'h5A, 1'b1, 1'b0, 3);
      waitDrain("drainSparse");

`ifdef FRAME_RX_PARITY_EN
      p0 = parityErrSeen;
      v0 = validSeen;
      applyStimulus(8'h03, 1'b1, 1'b1, 1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("parPulses", parityErrSeen - p0, 1);
      checkOutput("parValid", validSeen - v0, 0);
      checkOutput("parBusy", busy_o, 0);
`else
      p0 = parityErrSeen;
      checkOutput("noParityPulses", parityErrSeen - p0, 0);
`endif

      repeat (5) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
